// File: rtl/pdm_mic_emulator.sv
`default_nettype none
// ============================================================================
//  Module   : pdm_mic_emulator
//  Purpose  : PDM transmitter emulating a PDM microphone. Signed PCM samples
//             arrive over a valid/ready handshake, a first-order sigma-delta
//             modulator turns them into a 1-bit stream, and the block drives
//             pdm_clk/pdm_data the way a microphone presents them.
//  Ports    : clk, reset          - system clock, synchronous active-high reset
//             enable              - run the PDM clock and modulator
//             lr_sel              - 1: launch data on pdm_clk rise, 0: on fall
//             pcm_data/valid/ready- sample input handshake (one-entry buffer)
//             pdm_clk, pdm_data   - registered PDM clock and bitstream
//             pdm_oe              - high from the active edge to the opposite one
//             underrun            - 1-cycle pulse at a sample boundary with no sample
//  Revision : 1.0 - initial release
// ============================================================================
module pdm_mic_emulator #(
  parameter int HALF_DIV = 25,
  parameter int OSR      = 64,
  parameter int DATA_W   = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     lr_sel,
  input  logic signed [DATA_W-1:0] pcm_data,
  input  logic                     pcm_valid,
  output logic                     pcm_ready,
  output logic                     pdm_clk,
  output logic                     pdm_data,
  output logic                     pdm_oe,
  output logic                     underrun
);

  localparam int DIV_W = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
  localparam int BIT_W = (OSR > 1) ? $clog2(OSR) : 1;
  localparam int ACC_W = DATA_W + 2;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(HALF_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(OSR - 1);

  // Full-scale feedback values, sign-extended to the accumulator width.
  localparam logic signed [ACC_W-1:0] FB_POS = $signed({3'b000, {(DATA_W-1){1'b1}}});
  localparam logic signed [ACC_W-1:0] FB_NEG = $signed({3'b111, {(DATA_W-1){1'b0}}});

  logic [DIV_W-1:0]         div_cnt;
  logic [BIT_W-1:0]         bit_cnt;
  logic signed [ACC_W-1:0]  acc;
  logic signed [DATA_W-1:0] cur_sample;
  logic signed [DATA_W-1:0] sample_buf;
  logic                     buf_full;

  logic                     toggle;
  logic                     active;
  logic                     boundary;
  logic                     handshake;
  logic signed [ACC_W-1:0]  fb;
  logic signed [ACC_W-1:0]  acc_next;
  logic                     bit_next;

  assign pcm_ready = ~buf_full;
  assign handshake = pcm_valid & pcm_ready;

  // The cycle in which the pdm_clk register toggles; the active edge is the
  // toggle towards the level selected by lr_sel.
  assign toggle   = enable && (div_cnt == DIV_LAST);
  assign active   = toggle && (lr_sel ? ~pdm_clk : pdm_clk);
  assign boundary = active && (bit_cnt == BIT_LAST);

  // pdm_data holds the previous modulator bit, so it doubles as the feedback select.
  assign fb       = pdm_data ? FB_POS : FB_NEG;
  assign acc_next = acc + $signed({{2{cur_sample[DATA_W-1]}}, cur_sample}) - fb;
  assign bit_next = ~acc_next[ACC_W-1] && (acc_next != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt    <= '0;
      bit_cnt    <= '0;
      acc        <= '0;
      cur_sample <= '0;
      sample_buf <= '0;
      buf_full   <= 1'b0;
      pdm_clk    <= 1'b0;
      pdm_data   <= 1'b0;
      pdm_oe     <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      underrun <= 1'b0;

      // Sample buffer and boundary reload. A handshake cannot coincide with a
      // full buffer, so the bypass path only applies when the buffer is empty.
      if (boundary) begin
        if (buf_full) begin
          cur_sample <= sample_buf;
          buf_full   <= 1'b0;
        end else if (handshake) begin
          cur_sample <= pcm_data;
        end else begin
          cur_sample <= '0;
          underrun   <= 1'b1;
        end
      end else if (handshake) begin
        sample_buf <= pcm_data;
        buf_full   <= 1'b1;
      end

      if (!enable) begin
        div_cnt <= '0;
        bit_cnt <= '0;
        acc     <= '0;
        pdm_clk <= 1'b0;
        pdm_oe  <= 1'b0;
      end else begin
        if (toggle) begin
          div_cnt <= '0;
          pdm_clk <= ~pdm_clk;
          // Drive on the active edge, release on the opposite edge.
          pdm_oe  <= active;
        end else begin
          div_cnt <= div_cnt + DIV_W'(1);
        end

        if (active) begin
          acc      <= acc_next;
          pdm_data <= bit_next;
          bit_cnt  <= (bit_cnt == BIT_LAST) ? '0 : bit_cnt + BIT_W'(1);
        end
      end
    end
  end

endmodule
`default_nettype wire
